// File: rtl/frame_scanner_if.sv
// Bus between the snake game logic and frame_scanner: pixel writes, swap handshake and scan outputs.
// The game side uses the master modport; frame_scanner uses the slave modport.
interface frame_scanner_if #(
   parameter int rows    = 8,
   parameter int columns = 12,
   parameter int XW      = 4,
   parameter int YW      = 3
);
   logic               wr_en;
   logic [XW-1:0]      wr_x;
   logic [YW-1:0]      wr_y;
   logic               wr_val;
   logic               swap_req;
   logic               swap_ack;
   logic               busy;
   logic [rows-1:0]    rowOut;
   logic [columns-1:0] colOut;
   logic [XW-1:0]      col_idx;

   modport master (
      output wr_en, wr_x, wr_y, wr_val, swap_req,
      input  swap_ack, busy, rowOut, colOut, col_idx
   );

   modport slave (
      input  wr_en, wr_x, wr_y, wr_val, swap_req,
      output swap_ack, busy, rowOut, colOut, col_idx
   );
endinterface

// File: rtl/frame_scanner.sv
// Double-buffered rows x columns pixel store that scans the front buffer one column at a time.
// Optional feature CLEAR_ON_SWAP_EN: clears the new back buffer in the swap cycle.
module frame_scanner #(
   parameter int rows    = 8,
   parameter int columns = 12,
   parameter int hold    = 512,
   parameter int XW      = 4,
   parameter int YW      = 3
) (
   input logic              CLK,
   input logic              RST_N,
   frame_scanner_if.slave   bus
);
   localparam int              HW        = (hold > 1) ? $clog2(hold) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(hold - 1);
   localparam logic [XW-1:0]   LAST_COL  = XW'(columns - 1);
   localparam logic [YW-1:0]   LAST_ROW  = YW'(rows - 1);
   localparam logic [columns-1:0] COL_ONE = {{(columns-1){1'b0}}, 1'b1};

   logic [columns-1:0][rows-1:0] frame_mem [2];
   logic                         front_sel;
   logic [HW-1:0]                hold_cnt;
   logic [XW-1:0]                col_idx;
   logic                         busy;
   logic [rows-1:0]              row_q;
   logic [columns-1:0]           col_q;

   logic hold_last;
   logic frame_end;
   logic swap_fire;
   logic write_ok;

   assign hold_last = (hold_cnt == HOLD_LAST);
   assign frame_end = hold_last && (col_idx == LAST_COL);
   assign swap_fire = busy && frame_end;
   assign write_ok  = bus.wr_en && (bus.wr_x <= LAST_COL) && (bus.wr_y <= LAST_ROW);

   assign bus.swap_ack = swap_fire;
   assign bus.busy     = busy;
   assign bus.rowOut   = row_q;
   assign bus.colOut   = col_q;
   assign bus.col_idx  = col_idx;

   // Column scan: outputs are registered from the column index of the current cycle.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         hold_cnt <= '0;
         col_idx  <= '0;
         row_q    <= '0;
         col_q    <= '0;
      end else begin
         hold_cnt <= hold_last ? '0 : hold_cnt + HW'(1);
         if (hold_last)
            col_idx <= (col_idx == LAST_COL) ? '0 : col_idx + XW'(1);
         col_q <= COL_ONE << col_idx;
         row_q <= frame_mem[front_sel][col_idx];
      end
   end

   // A request seen while idle is latched; further requests are dropped until the swap lands.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         busy      <= 1'b0;
         front_sel <= 1'b0;
      end else if (swap_fire) begin
         busy      <= 1'b0;
         front_sel <= ~front_sel;
      end else if (bus.swap_req) begin
         busy <= 1'b1;
      end
   end

   // Writes use the pre-swap back buffer, so a write in the swap cycle lands in the new front.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         frame_mem[0] <= '0;
         frame_mem[1] <= '0;
      end else begin
`ifdef CLEAR_ON_SWAP_EN
         if (swap_fire)
            frame_mem[front_sel] <= '0;
`endif
         if (write_ok)
            frame_mem[~front_sel][bus.wr_x][bus.wr_y] <= bus.wr_val;
      end
   end
endmodule
